// File: rtl/gray_arb_pkg.sv
// rtl/gray_arb_pkg.sv - shared defaults and width helpers for the gray conversion arbiter
package gray_arb_pkg;

  localparam int NREQ_DEFAULT = 4;
  localparam int W_DEFAULT    = 8;
  localparam int ID_W         = $clog2(NREQ_DEFAULT);
  localparam int CNT_W        = 16;

  // A single requester still needs a one-bit id field.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/binary_to_gray.sv
// rtl/binary_to_gray.sv - combinational binary to reflected Gray code converter
module binary_to_gray #(
  parameter int W = 8
) (
  input  logic [W-1:0] bin,
  output logic [W-1:0] gray
);

  always_comb begin
    gray        = '0;
    gray[W-1]   = bin[W-1];
    for (int k = 0; k < W - 1; k++) begin
      gray[k] = bin[k+1] ^ bin[k];
    end
  end

endmodule

// File: rtl/gray_conv_arbiter.sv
// rtl/gray_conv_arbiter.sv - round-robin arbiter feeding one Gray converter into a one-deep result register
module gray_conv_arbiter
  import gray_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT,
  parameter int W    = W_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*W-1:0]         req_data,
  output logic [NREQ-1:0]           req_ready,
  output logic                      out_valid,
  output logic [W-1:0]              out_gray,
  output logic [id_width(NREQ)-1:0] out_id,
  input  logic                      out_ready,
  output logic [CNT_W-1:0]          conv_count
);

  localparam int IDW = id_width(NREQ);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] grant_idx;
  logic [IDW-1:0] cand;
  logic           any_req;
  logic           slot_free;
  logic           transfer;
  logic [W-1:0]   operand;
  logic [W-1:0]   gray_w;

  assign slot_free = !out_valid || out_ready;

  // NREQ is a power of two, so the IDW-bit sum wraps the search modulo NREQ.
  always_comb begin
    any_req   = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = ptr + IDW'(k);
      if (!any_req && req_valid[cand]) begin
        any_req   = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && slot_free && any_req) begin
      req_ready = NREQ'(1) << grant_idx;
    end
  end

  assign transfer = |(req_valid & req_ready);

  always_comb begin
    operand = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        operand = req_data[i*W +: W];
      end
    end
  end

  binary_to_gray #(
    .W (W)
  ) u_b2g (
    .bin  (operand),
    .gray (gray_w)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_gray   <= '0;
      out_id     <= '0;
      ptr        <= '0;
      conv_count <= '0;
    end else if (transfer) begin
      out_valid  <= 1'b1;
      out_gray   <= gray_w;
      out_id     <= grant_idx;
      ptr        <= grant_idx + IDW'(1);
      conv_count <= conv_count + CNT_W'(1);
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// tb/tb_gray_conv_arbiter.sv - self-checking bench for gray_conv_arbiter
module tb_gray_conv_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic [7:0]  out_gray;
  logic [1:0]  out_id;
  logic        out_ready;
  logic [15:0] conv_count;

  int tests = 0;
  int fails = 0;

  int          ptr_m;
  bit          valid_m;
  logic [7:0]  gray_m;
  int          id_m;
  logic [15:0] cnt_m;

  gray_conv_arbiter #(.NREQ(4), .W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .out_valid  (out_valid),
    .out_gray   (out_gray),
    .out_id     (out_id),
    .out_ready  (out_ready),
    .conv_count (conv_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0]  v;
    logic [31:0] d;
    logic        r;
    logic [3:0]  exp_ready;
    logic        exp_valid;
    logic [7:0]  exp_gray;
    logic [1:0]  exp_id;
    logic [15:0] exp_cnt;
  } vec_t;

  function automatic logic [7:0] gray_f(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ptr_m   = 0;
    valid_m = 1'b0;
    gray_m  = '0;
    id_m    = 0;
    cnt_m   = '0;
  endtask

  // Asserts reset away from any rising edge so the clear must be asynchronous.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_conv_count", 32'(conv_count), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // One clock: drive, check the combinational grant, then the registered result.
  task automatic cycle(input logic [3:0] v, input logic [31:0] d, input logic r,
                       output logic [3:0] rdy_seen);
    int g;
    logic [3:0] exp_rdy;
    req_valid = v;
    req_data  = d;
    out_ready = r;
    #1;
    g = -1;
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (ptr_m + k) % 4;
      if (g < 0 && v[idx]) g = idx;
    end
    exp_rdy = ((!valid_m || r) && g >= 0) ? (4'b0001 << g) : 4'b0000;
    rdy_seen = req_ready;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    @(posedge clk);
    if (exp_rdy != 4'b0000) begin
      valid_m = 1'b1;
      gray_m  = gray_f(d[g*8 +: 8]);
      id_m    = g;
      ptr_m   = (g + 1) % 4;
      cnt_m   = cnt_m + 16'd1;
    end else if (r) begin
      valid_m = 1'b0;
    end
    #1;
    check("out_valid", 32'(out_valid), 32'(valid_m));
    if (valid_m) begin
      check("out_gray", 32'(out_gray), 32'(gray_m));
      check("out_id", 32'(out_id), 32'(id_m));
    end
    check("conv_count", 32'(conv_count), 32'(cnt_m));
  endtask

  vec_t tab[9];
  logic [7:0] stream_exp[8];
  logic [3:0] rdy;

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b0;
    model_reset();

    tab[0] = '{4'b1111, 32'h04030201, 1'b1, 4'b0001, 1'b1, 8'h01, 2'd0, 16'd1};
    tab[1] = '{4'b1111, 32'h04030201, 1'b1, 4'b0010, 1'b1, 8'h03, 2'd1, 16'd2};
    tab[2] = '{4'b1111, 32'h04030201, 1'b1, 4'b0100, 1'b1, 8'h02, 2'd2, 16'd3};
    tab[3] = '{4'b1111, 32'h04030201, 1'b1, 4'b1000, 1'b1, 8'h06, 2'd3, 16'd4};
    tab[4] = '{4'b1111, 32'h04030201, 1'b1, 4'b0001, 1'b1, 8'h01, 2'd0, 16'd5};
    tab[5] = '{4'b1111, 32'h04030201, 1'b1, 4'b0010, 1'b1, 8'h03, 2'd1, 16'd6};
    tab[6] = '{4'b0001, 32'h0000000A, 1'b1, 4'b0001, 1'b1, 8'h0F, 2'd0, 16'd7};
    tab[7] = '{4'b0001, 32'h000000FF, 1'b1, 4'b0001, 1'b1, 8'h80, 2'd0, 16'd8};
    tab[8] = '{4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 16'd8};
    stream_exp = '{8'h00, 8'h01, 8'h03, 8'h02, 8'h06, 8'h07, 8'h05, 8'h04};

    do_reset();

    for (int i = 0; i < 9; i++) begin
      cycle(tab[i].v, tab[i].d, tab[i].r, rdy);
      check($sformatf("tab%0d_ready", i), 32'(rdy), 32'(tab[i].exp_ready));
      check($sformatf("tab%0d_valid", i), 32'(out_valid), 32'(tab[i].exp_valid));
      if (tab[i].exp_valid) begin
        check($sformatf("tab%0d_gray", i), 32'(out_gray), 32'(tab[i].exp_gray));
        check($sformatf("tab%0d_id", i), 32'(out_id), 32'(tab[i].exp_id));
      end
      check($sformatf("tab%0d_cnt", i), 32'(conv_count), 32'(tab[i].exp_cnt));
    end

    // Backpressure: hold a result for three cycles, then release into a new grant.
    cycle(4'b1111, 32'h11223344, 1'b1, rdy);
    for (int i = 0; i < 3; i++) begin
      cycle(4'b1111, 32'h55667788, 1'b0, rdy);
      check("bp_ready_zero", 32'(rdy), 32'd0);
      check("bp_gray_held", 32'(out_gray), 32'(gray_f(8'h33)));
    end
    cycle(4'b1111, 32'h55667788, 1'b1, rdy);
    check("bp_release_grant", 32'(rdy != 4'b0000), 32'd1);

    // Reset mid-stream with requests still pending; first grant goes to 0.
    cycle(4'b1111, 32'hA1B2C3D4, 1'b0, rdy);
    do_reset();
    cycle(4'b1111, 32'hA1B2C3D4, 1'b1, rdy);
    check("post_rst_id", 32'(out_id), 32'd0);
    check("post_rst_ready", 32'(rdy), 32'd1);

    // Lone streamer on requester 2.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      cycle(4'b0100, 32'(k) << 16, 1'b1, rdy);
      check($sformatf("stream%0d_gray", k), 32'(out_gray), 32'(stream_exp[k]));
      check($sformatf("stream%0d_valid", k), 32'(out_valid), 32'd1);
      check($sformatf("stream%0d_id", k), 32'(out_id), 32'd2);
    end

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cycle(4'($urandom), $urandom, ($urandom_range(0, 3) != 0), rdy);
    end

    // Counter wrap after 65536 transfers.
    do_reset();
    req_valid = 4'b0100;
    req_data  = 32'h005A0000;
    out_ready = 1'b1;
    repeat (65536) @(posedge clk);
    #1;
    check("wrap_count", 32'(conv_count), 32'd0);
    check("wrap_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
    check("wrap_count_plus1", 32'(conv_count), 32'd1);
    do_reset();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gray_conv_arbiter.md
GRAY_CONV_ARBITER -- requirements
Module: gray_conv_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4: number of requesters (power of two, 2..8).
REQ-002 The block SHALL have parameter W, default 8: data width of each conversion.
REQ-003 The block SHALL have port clk, input, 1: single clock, all state updates on rising edge.
REQ-004 The block SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 The block SHALL have port req_valid, input, NREQ: per-requester conversion request.
REQ-006 The block SHALL have port req_data, input, NREQ*W: packed binary operands, requester i at bits [i*W +: W].
REQ-007 The block SHALL have port req_ready, output, NREQ: one-hot grant/accept, combinational.
REQ-008 The block SHALL have port out_valid, output, 1: registered result valid.
REQ-009 The block SHALL have port out_gray, output, W: registered Gray code of the granted operand.
REQ-010 The block SHALL have port out_id, output, log2(NREQ): index of the requester that owns out_gray.
REQ-011 The block SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-012 The block SHALL have port conv_count, output, 16: total accepted conversions, wraps modulo 2^16.

Function
REQ-013 The block SHALL be able to accept a request (slot free) when out_valid=0 or out_ready=1.
REQ-014 When the slot is free and any req_valid is set, the block SHALL assert exactly one req_ready bit, chosen round-robin; otherwise req_ready SHALL be all zero.
REQ-015 Round-robin SHALL search from priority pointer ptr upward, modulo NREQ; after a grant to i, ptr SHALL become (i+1) mod NREQ, wrapping NREQ-1 -> 0.
REQ-016 ptr SHALL be unchanged in cycles with no grant.
REQ-017 A transfer on requester i SHALL occur when req_valid[i] and req_ready[i] are both 1.
REQ-018 On a transfer, the next edge SHALL load out_gray = gray(operand), out_id = i, out_valid = 1, giving latency 1 cycle.
REQ-019 gray(b) SHALL be b XOR (b >> 1): MSB passes through, bit k = b[k+1] XOR b[k].
REQ-020 When out_ready=1 and no transfer occurs, out_valid SHALL clear on the next edge.
REQ-021 While out_valid=1 and out_ready=0, out_valid, out_gray and out_id SHALL hold stable, and req_ready SHALL be all zero.
REQ-022 If a result is consumed and a new transfer occurs in the same cycle, the new result SHALL replace it back-to-back, sustaining 1 conversion per cycle.
REQ-023 conv_count SHALL increment by 1 per transfer and wrap 16'hFFFF -> 16'h0000.
REQ-024 req_valid deasserted without a grant SHALL be legal; the block SHALL keep no memory of withdrawn requests.

Reset
REQ-025 rst_n low SHALL immediately clear out_valid, out_gray, out_id, ptr and conv_count to 0, independent of clk.
REQ-026 req_ready SHALL be all zero while rst_n is low.
REQ-027 Reset mid-operation SHALL discard any held result; the first grant after release SHALL start from requester 0.

Structure
REQ-028 Package gray_arb_pkg SHALL hold the NREQ and W defaults, the ID width constant and the count width (16).
REQ-029 The conversion SHALL use a single instance of the combinational sub-module binary_to_gray, fed by the grant mux.
REQ-030 The round-robin arbiter, output register and counter SHALL reside in gray_conv_arbiter.

Verification
REQ-031 The bench SHALL cover reset: assert rst_n=0 mid-stream -> out_valid=0, conv_count=0, req_ready=0 asynchronously; the next grant goes to id 0.
REQ-032 The bench SHALL cover single request: req_valid=4'b0001, data0=8'h0A, out_ready=1 -> next cycle out_gray=8'h0F, out_id=0; with data0=8'hFF -> out_gray=8'h80.
REQ-033 The bench SHALL cover fairness: req_valid=4'b1111 held, out_ready=1 -> grant order 0,1,2,3,0,1, and conv_count advances by 1 per cycle.
REQ-034 The bench SHALL cover backpressure: out_ready=0 for 3 cycles with a result held -> outputs stable, req_ready=0; release -> the next grant follows in the same cycle.
REQ-035 The bench SHALL cover a lone streamer: only req_valid[2]=1 with data 8'h00..8'h07 -> 8 consecutive results 00,01,03,02,06,07,05,04 with id 2 and no bubbles.
REQ-036 The bench SHALL cover counter wrap: preload via 65536 transfers -> conv_count returns to 16'h0000.
